sensors_scan_avg: RTL and testbench
===================================

// Module: sensors_scan_avg
// PURPOSE
//  Sequential, parametrised temperature aggregator for NR_SENSORS sensors.
//  On a start request it snapshots all sensor readings and enable bits, then scans one sensor per clock.
//  It produces the sum, active-sensor count, minimum, maximum and truncated average of the enabled sensors.
//  Results are returned through a valid/ready handshake to the temperature control logic.
// PARAMETERS
//  NR_SENSORS  5  number of sensor channels (>=1)
//  DATA_W      8  width of one sensor reading, unsigned
//  CNT_W       $clog2(NR_SENSORS+1)  derived; width of the active-sensor count
//  SUM_W       DATA_W+CNT_W          derived; width of the sum, cannot overflow
// PORTS
//  clk_i                in   1                   single clock, rising edge
//  rst_i                in   1                   asynchronous, active-high reset
//  start_i              in   1                   start request; sampled only in IDLE
//  sensors_data_i       in   NR_SENSORS*DATA_W   sensor k occupies [DATA_W*k +: DATA_W]
//  sensors_en_i         in   NR_SENSORS          bit k=1: sensor k participates
//  busy_o               out  1                   high in SCAN, DIVIDE and DONE
//  valid_o              out  1                   result valid; held until ready_i
//  ready_i              in   1                   consumer accepts the result
//  temp_sum_o           out  SUM_W               sum of active readings
//  nr_active_sensors_o  out  CNT_W               popcount of the enable snapshot
//  temp_avg_o           out  DATA_W              floor(sum/count)
//  temp_min_o, temp_max_o  out  DATA_W           min/max over active readings
//  no_active_o          out  1                   snapshot had no enabled sensor
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs and internal registers are 0.
//  - FSM states: IDLE, SCAN, DIVIDE, DONE.
//  - IDLE, start_i=1: snapshot data and en; clear sum/count/idx; min<=all-ones, max<=0; go to SCAN.
//  - SCAN: one cycle per index idx=0..NR_SENSORS-1.
//    - If en[idx]: sum+=d, count+=1, min/max updated.
//    - After idx=NR_SENSORS-1: go to DIVIDE if count>0, else go to DONE.
//  - DIVIDE: restoring division of sum by count, one quotient bit per cycle, SUM_W cycles; then DONE.
//    - The quotient is always <= max, so its low DATA_W bits are the average.
//  - DONE: valid_o=1 and result outputs stable.
//    - On valid_o && ready_i: go to IDLE and drop valid_o the next cycle. Results stay held until the next start.
//  - Latency (start edge to valid_o high): NR_SENSORS+SUM_W+1 cycles if count>0, else NR_SENSORS+1.
//  - count=0: sum=0, avg=0, min=0, max=0, no_active_o=1.
//  - start_i while busy_o: ignored, not queued. start_i in the same cycle as the DONE handshake: ignored.
//  - Input changes after the snapshot cycle do not affect the running computation.
//  - Reset asserted mid-operation: immediate return to IDLE with all outputs 0; the computation is lost.
//  - A single active sensor: min=max=avg=its reading.
// STRUCTURE
//  - Package sensors_pkg holds:
//    - state_t enum {IDLE, SCAN, DIVIDE, DONE};
//    - functions cnt_w(n) and sum_w(n,dw).
//  - One sub-module, seq_divider: restoring divider.
//    - Parameters DVD_W=SUM_W and DVS_W=CNT_W.
//    - Ports start/dividend/divisor/quotient/done.
//    - The top FSM waits on its done.
// TESTING (NR_SENSORS=5, DATA_W=8, SUM_W=11)
//  - data s0..s4={20,30,25,40,10}, en=5'b10111 -> sum=85, cnt=4, avg=21, min=10, max=30; valid_o 17 cycles after start.
//  - all readings 255, en=5'b11111 -> sum=1275, cnt=5, avg=255, min=max=255 (no overflow).
//  - en=5'b00000 -> no_active_o=1, sum=avg=min=max=0, valid_o 6 cycles after start, no DIVIDE.
//  - ready_i held low 10 cycles in DONE with inputs changed -> outputs unchanged, valid_o high; ready_i=1 -> IDLE.
//  - start_i pulsed during SCAN and DIVIDE -> no restart; the result equals the first snapshot's.
//  - rst_i asserted in DIVIDE cycle 4 -> outputs 0, state IDLE.
//    A new start then produces a correct result.

Source files
------------

// File: rtl/sensors_scan_avg_pkg.sv
// Shared types and width helpers for the sensor scan/average block.
package sensors_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Sum of n readings of dw bits each can never overflow this width.
  function automatic int sum_w(input int n, input int dw);
    return dw + cnt_w(n);
  endfunction

endpackage

// File: rtl/sensors_scan_avg_if.sv
// Request/result bundle between the temperature control logic and the aggregator.
interface sensors_scan_avg_if #(
    parameter int NR_SENSORS = 5,
    parameter int DATA_W     = 8
);
    import sensors_pkg::*;

    localparam int CNT_W = cnt_w(NR_SENSORS);
    localparam int SUM_W = sum_w(NR_SENSORS, DATA_W);

    // valid_o/ready_i: a result transfers on a cycle where both are high;
    // valid_o stays high and the result stays stable until that cycle.
    logic                         start_i;
    logic [NR_SENSORS*DATA_W-1:0] sensors_data_i;
    logic [NR_SENSORS-1:0]        sensors_en_i;
    logic                         ready_i;
    logic                         busy_o;
    logic                         valid_o;
    logic [SUM_W-1:0]             temp_sum_o;
    logic [CNT_W-1:0]             nr_active_sensors_o;
    logic [DATA_W-1:0]            temp_avg_o;
    logic [DATA_W-1:0]            temp_min_o;
    logic [DATA_W-1:0]            temp_max_o;
    logic                         no_active_o;
    state_t                       state_o;

    modport slave (
        input  start_i, sensors_data_i, sensors_en_i, ready_i,
        output busy_o, valid_o, temp_sum_o, nr_active_sensors_o, temp_avg_o,
               temp_min_o, temp_max_o, no_active_o, state_o
    );

    modport master (
        output start_i, sensors_data_i, sensors_en_i, ready_i,
        input  busy_o, valid_o, temp_sum_o, nr_active_sensors_o, temp_avg_o,
               temp_min_o, temp_max_o, no_active_o, state_o
    );

endinterface

// File: rtl/sensors_scan_avg_seq_divider.sv
// Restoring divider: one quotient bit per clock, DVD_W steps after start_i.
module seq_divider #(
    parameter int DVD_W = 11,
    parameter int DVS_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [DVD_W-1:0] quotient_o,
    output logic             done_o
);
    localparam int CW = $clog2(DVD_W + 1);

    logic [DVD_W-1:0] quo_q;
    logic [DVS_W-1:0] rem_q;
    logic [DVS_W-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [DVS_W:0]   shifted;
    logic [DVS_W:0]   trial;
    logic             fits;

    // Remainder stays below the divisor, so DVS_W+1 bits hold the shifted value
    // and the top bit of the trial subtraction is the borrow.
    assign shifted = {rem_q, quo_q[DVD_W-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign fits    = ~trial[DVS_W];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            quo_q  <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
            cnt_q  <= CW'(DVD_W);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= fits ? trial[DVS_W-1:0] : shifted[DVS_W-1:0];
            quo_q  <= {quo_q[DVD_W-2:0], fits};
            cnt_q  <= cnt_q - CW'(1);
            busy_q <= (cnt_q != CW'(1));
        end
    end

    // Flags the cycle of the final step so the caller can leave on the same edge.
    assign done_o     = busy_q && (cnt_q == CW'(1));
    assign quotient_o = quo_q;

endmodule

// File: rtl/sensors_scan_avg.sv
// Snapshot NR_SENSORS readings, scan one per clock, then divide for the average.
module sensors_scan_avg #(
    parameter int NR_SENSORS = 5,
    parameter int DATA_W     = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    sensors_scan_avg_if.slave bus
);
    import sensors_pkg::*;

    localparam int CNT_W = cnt_w(NR_SENSORS);
    localparam int SUM_W = sum_w(NR_SENSORS, DATA_W);
    localparam int DAT_T = NR_SENSORS * DATA_W;

    state_t            state_q, state_d;
    logic [DAT_T-1:0]  data_q, data_d;
    logic [NR_SENSORS-1:0] en_q, en_d;
    logic [CNT_W-1:0]  idx_q, idx_d, cnt_q, cnt_d, ocnt_q, ocnt_d;
    logic [SUM_W-1:0]  sum_q, sum_d, osum_q, osum_d;
    logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
    logic [DATA_W-1:0] oavg_q, oavg_d, omin_q, omin_d, omax_q, omax_d;
    logic              onone_q, onone_d, valid_q, valid_d;
    logic              last_scan, div_start, div_done, busy;
    logic [DATA_W-1:0] cur;
    logic [SUM_W-1:0]  quotient;

    seq_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W)) u_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (div_start),
        .dividend_i(sum_d),
        .divisor_i (cnt_d),
        .quotient_o(quotient),
        .done_o    (div_done)
    );

    // The snapshot shifts down one sensor per scan cycle, so the current one is always at bit 0.
    assign cur       = data_q[DATA_W-1:0];
    assign last_scan = (idx_q == CNT_W'(NR_SENSORS - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start_i) state_d = SCAN;
            SCAN:    if (last_scan) state_d = (cnt_d != '0) ? DIVIDE : DONE;
            DIVIDE:  if (div_done) state_d = DONE;
            DONE:    if (valid_q && bus.ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        div_start = (state_q == SCAN) && last_scan && (cnt_d != '0);
    end

    always_comb begin
        data_d  = data_q;
        en_d    = en_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        min_d   = min_q;
        max_d   = max_q;
        osum_d  = osum_q;
        ocnt_d  = ocnt_q;
        oavg_d  = oavg_q;
        omin_d  = omin_q;
        omax_d  = omax_q;
        onone_d = onone_q;
        valid_d = valid_q;
        if (state_q == IDLE && bus.start_i) begin
            data_d = bus.sensors_data_i;
            en_d   = bus.sensors_en_i;
            idx_d  = '0;
            cnt_d  = '0;
            sum_d  = '0;
            min_d  = '1;
            max_d  = '0;
        end else if (state_q == SCAN) begin
            data_d = data_q >> DATA_W;
            en_d   = en_q >> 1;
            idx_d  = idx_q + CNT_W'(1);
            if (en_q[0]) begin
                sum_d = sum_q + SUM_W'(cur);
                cnt_d = cnt_q + CNT_W'(1);
                if (cur < min_q) min_d = cur;
                if (cur > max_q) max_d = cur;
            end
        end else if (state_q == DONE && !valid_q) begin
            // Results are registered on the first DONE cycle; the quotient bound (<= max) makes the clamp dead.
            valid_d = 1'b1;
            onone_d = (cnt_q == '0);
            osum_d  = sum_q;
            ocnt_d  = cnt_q;
            omax_d  = max_q;
            omin_d  = (cnt_q == '0) ? '0 : min_q;
            if (cnt_q == '0)                     oavg_d = '0;
            else if (|quotient[SUM_W-1:DATA_W])  oavg_d = '1;
            else                                 oavg_d = quotient[DATA_W-1:0];
        end else if (state_q == DONE && bus.ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            en_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            osum_q  <= '0;
            ocnt_q  <= '0;
            oavg_q  <= '0;
            omin_q  <= '0;
            omax_q  <= '0;
            onone_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            en_q    <= en_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            osum_q  <= osum_d;
            ocnt_q  <= ocnt_d;
            oavg_q  <= oavg_d;
            omin_q  <= omin_d;
            omax_q  <= omax_d;
            onone_q <= onone_d;
            valid_q <= valid_d;
        end
    end

    assign bus.busy_o              = busy;
    assign bus.valid_o             = valid_q;
    assign bus.temp_sum_o          = osum_q;
    assign bus.nr_active_sensors_o = ocnt_q;
    assign bus.temp_avg_o          = oavg_q;
    assign bus.temp_min_o          = omin_q;
    assign bus.temp_max_o          = omax_q;
    assign bus.no_active_o         = onone_q;
    assign bus.state_o             = state_q;

endmodule

// File: tb/tb_sensors_scan_avg.sv
// Scoreboard bench for sensors_scan_avg with NR_SENSORS=5, DATA_W=8.
module tb_sensors_scan_avg;
    import sensors_pkg::*;

    localparam int NR = 5;
    localparam int DW = 8;
    localparam int RW = 39;  // {none, sum[10:0], cnt[2:0], avg, min, max}

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [RW-1:0] exp_q[$];
    int            lat_q[$];

    sensors_scan_avg_if #(.NR_SENSORS(NR), .DATA_W(DW)) bus ();

    sensors_scan_avg #(.NR_SENSORS(NR), .DATA_W(DW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] model(input logic [NR*DW-1:0] d, input logic [NR-1:0] en);
        int sum, cnt, mn, mx, v;
        sum = 0; cnt = 0; mn = 255; mx = 0;
        for (int k = 0; k < NR; k++) begin
            if (en[k]) begin
                v = int'(d[DW*k +: DW]);
                sum += v;
                cnt++;
                if (v < mn) mn = v;
                if (v > mx) mx = v;
            end
        end
        if (cnt == 0) return {1'b1, 38'd0};
        return {1'b0, 11'(sum), 3'(cnt), 8'(sum / cnt), 8'(mn), 8'(mx)};
    endfunction

    function automatic logic [RW-1:0] observed();
        return {bus.no_active_o, bus.temp_sum_o, bus.nr_active_sensors_o,
                bus.temp_avg_o, bus.temp_min_o, bus.temp_max_o};
    endfunction

    function automatic logic [NR*DW-1:0] rand_data();
        logic [NR*DW-1:0] d;
        for (int k = 0; k < NR; k++) d[DW*k +: DW] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    task automatic scramble_inputs();
        bus.sensors_data_i = rand_data();
        bus.sensors_en_i   = 5'($urandom_range(0, 31));
    endtask

    task automatic run_scan(input logic [NR*DW-1:0] d, input logic [NR-1:0] en,
                            input int hold, input bit pulse, input bit start_at_hs);
        logic [RW-1:0] exp, got;
        int exp_lat, n;
        bit seen;
        exp = model(d, en);
        exp_q.push_back(exp);
        lat_q.push_back(en != '0 ? NR + 11 + 1 : NR + 1);
        bus.sensors_data_i = d;
        bus.sensors_en_i   = en;
        bus.start_i        = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        scramble_inputs();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clk); #1;
            n++;
            bus.start_i = pulse && (n == 3 || n == 10);
            if (n == 4) scramble_inputs();
            seen = bus.valid_o;
        end
        bus.start_i = 1'b0;
        exp     = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        check_eq("valid_seen", 64'(seen), 64'd1);
        if (!seen) return;
        check_eq("latency", 64'(n), 64'(exp_lat));
        got = observed();
        check_eq("no_active", 64'(got[38]), 64'(exp[38]));
        check_eq("sum", 64'(got[37:27]), 64'(exp[37:27]));
        check_eq("count", 64'(got[26:24]), 64'(exp[26:24]));
        check_eq("avg", 64'(got[23:16]), 64'(exp[23:16]));
        check_eq("min", 64'(got[15:8]), 64'(exp[15:8]));
        check_eq("max", 64'(got[7:0]), 64'(exp[7:0]));
        check_eq("busy_done", 64'(bus.busy_o), 64'd1);
        for (int i = 0; i < hold; i++) begin
            scramble_inputs();
            @(posedge clk); #1;
            check_eq("hold_valid", 64'(bus.valid_o), 64'd1);
            check_eq("hold_result", 64'(observed()), 64'(exp));
        end
        bus.ready_i = 1'b1;
        bus.start_i = start_at_hs;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        bus.start_i = 1'b0;
        check_eq("valid_drop", 64'(bus.valid_o), 64'd0);
        check_eq("state_idle", 64'(bus.state_o), 64'(IDLE));
        check_eq("result_held", 64'(observed()), 64'(exp));
        if (start_at_hs) begin
            @(posedge clk); #1;
            check_eq("hs_start_ignored", 64'(bus.busy_o), 64'd0);
        end
    endtask

    task automatic abort_in_divide(input logic [NR*DW-1:0] d, input logic [NR-1:0] en);
        bus.sensors_data_i = d;
        bus.sensors_en_i   = en;
        bus.start_i        = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        check_eq("pre_abort_state", 64'(bus.state_o), 64'(DIVIDE));
        rst = 1'b1;
        #1;
        check_eq("abort_state", 64'(bus.state_o), 64'(IDLE));
        check_eq("abort_busy", 64'(bus.busy_o), 64'd0);
        check_eq("abort_valid", 64'(bus.valid_o), 64'd0);
        check_eq("abort_result", 64'(observed()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.start_i        = 1'b0;
        bus.ready_i        = 1'b0;
        bus.sensors_data_i = '0;
        bus.sensors_en_i   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_state", 64'(bus.state_o), 64'(IDLE));
        check_eq("rst_busy", 64'(bus.busy_o), 64'd0);
        check_eq("rst_valid", 64'(bus.valid_o), 64'd0);
        check_eq("rst_result", 64'(observed()), 64'd0);

        run_scan({8'd10, 8'd40, 8'd25, 8'd30, 8'd20}, 5'b10111, 0, 1'b0, 1'b0);
        run_scan({NR{8'd255}}, 5'b11111, 0, 1'b0, 1'b0);
        run_scan(rand_data(), 5'b00000, 0, 1'b0, 1'b0);
        run_scan(rand_data(), 5'b01101, 10, 1'b0, 1'b0);
        run_scan(rand_data(), 5'b11011, 0, 1'b1, 1'b0);
        run_scan(rand_data(), 5'b00000, 2, 1'b1, 1'b1);
        run_scan({8'd1, 8'd2, 8'd177, 8'd4, 8'd5}, 5'b00100, 0, 1'b0, 1'b1);
        run_scan({8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 5'b11111, 0, 1'b0, 1'b0);
        abort_in_divide({8'd90, 8'd80, 8'd70, 8'd60, 8'd50}, 5'b11111);
        run_scan({8'd3, 8'd200, 8'd17, 8'd99, 8'd64}, 5'b11110, 0, 1'b0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            run_scan(rand_data(), 5'($urandom_range(0, 31)), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
